// File: rtl/register_write_controller_pkg.sv
// Shared widths, typedefs and FSM state encoding for the general-register write path.
package reg_pkg;
  localparam int unsigned REG_DATA_W  = 4;
  localparam int unsigned NUM_GP_REGS = 4;
  localparam int unsigned REG_ADDR_W  = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef enum logic [0:0] {IDLE, ISSUE} wr_state_t;
endpackage

// File: rtl/register_write_controller_if.sv
// Result-source handshake bundle: ALU and memory-load valid/ready request channels.
interface register_write_controller_if
  import reg_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    output alu_ready, mem_ready
  );
endinterface

// File: rtl/register_write_controller_rr_arbiter2.sv
// Two-requester round-robin arbiter; req[0] is the ALU, req[1] the memory load.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // ptr_q names the requester that wins the next contested cycle.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (!hold) begin
      if (&req) begin
        gnt[ptr_q] = 1'b1;
        ptr_d      = ~ptr_q;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/register_write_controller.sv
// Arbitrates ALU/load results and turns each accepted one into a registered one-hot write pulse.
module register_write_controller
  import reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_GP_REGS,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned DATA_W   = REG_DATA_W,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        freeze,
  register_write_controller_if.slave  src,
  output logic [NUM_REGS-1:0]         reg_set,
  output logic [DATA_W-1:0]           reg_value,
  output logic                        busy,
  output logic [CNT_W-1:0]            write_count,
  output logic                        err_dest
);
  logic [1:0]          gnt;
  logic                accept;
  logic [ADDR_W-1:0]   sel_dest;
  logic [DATA_W-1:0]   sel_data;
  logic                in_range;

  wr_state_t           state_q, state_d;
  logic [NUM_REGS-1:0] reg_set_q, reg_set_d;
  logic [DATA_W-1:0]   reg_value_q, reg_value_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .hold  (freeze),
    .req   ({src.mem_valid, src.alu_valid}),
    .gnt   (gnt)
  );

  assign src.alu_ready = gnt[0];
  assign src.mem_ready = gnt[1];

  assign accept   = |gnt;
  assign sel_dest = gnt[1] ? src.mem_dest : src.alu_dest;
  assign sel_data = gnt[1] ? src.mem_data : src.alu_data;
  assign in_range = 32'(sel_dest) < NUM_REGS;

  always_comb begin
    state_d     = state_q;
    reg_set_d   = '0;
    reg_value_d = reg_value_q;
    count_d     = count_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      // Out-of-range writes are counted and flagged but never strobe a register.
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        reg_set_d[i] = (32'(sel_dest) == i);
      end
      reg_value_d = sel_data;
      count_d     = count_q + CNT_W'(1);
      if (!in_range) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      reg_set_q   <= '0;
      reg_value_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_set_q   <= reg_set_d;
      reg_value_q <= reg_value_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign reg_set     = reg_set_q;
  assign reg_value   = reg_value_q;
  assign busy        = (state_q == ISSUE);
  assign write_count = count_q;
  assign err_dest    = err_q;
endmodule

// File: tb/tb_register_write_controller.sv
// Scoreboard bench: two DUTs (4 and 3 registers) driven identically, checked against a model.
module tb_register_write_controller;
  logic       clock;
  logic       reset;
  logic       freeze;

  logic [3:0] reg_set4;
  logic [3:0] reg_value4;
  logic       busy4;
  logic [7:0] write_count4;
  logic       err_dest4;

  logic [2:0] reg_set3;
  logic [3:0] reg_value3;
  logic       busy3;
  logic [7:0] write_count3;
  logic       err_dest3;

  register_write_controller_if #(.ADDR_W(2), .DATA_W(4)) bus4 ();
  register_write_controller_if #(.ADDR_W(2), .DATA_W(4)) bus3 ();

  register_write_controller #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(4), .CNT_W(8)) dut4 (
    .clock       (clock),
    .reset       (reset),
    .freeze      (freeze),
    .src         (bus4),
    .reg_set     (reg_set4),
    .reg_value   (reg_value4),
    .busy        (busy4),
    .write_count (write_count4),
    .err_dest    (err_dest4)
  );

  register_write_controller #(.NUM_REGS(3), .ADDR_W(2), .DATA_W(4), .CNT_W(8)) dut3 (
    .clock       (clock),
    .reset       (reset),
    .freeze      (freeze),
    .src         (bus3),
    .reg_set     (reg_set3),
    .reg_value   (reg_value3),
    .busy        (busy3),
    .write_count (write_count3),
    .err_dest    (err_dest3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [3:0] set4;
    logic [2:0] set3;
    logic [3:0] val;
    bit         in3;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model state.
  bit         rr_alu;
  logic [7:0] exp_cnt;
  logic [3:0] last_val4;
  bit         exp_err3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_write(input logic [1:0] dest, input logic [3:0] data);
    exp_t e;
    e.set4 = 4'b0001 << dest;
    e.in3  = (dest < 2'd3);
    e.set3 = e.in3 ? (3'b001 << dest) : 3'b000;
    e.val  = data;
    sbq.push_back(e);
    exp_cnt   = exp_cnt + 8'd1;
    last_val4 = data;
    if (!e.in3) exp_err3 = 1'b1;
  endtask

  task automatic drive(input bit fr, input bit av, input logic [1:0] ad, input logic [3:0] adat,
                       input bit mv, input logic [1:0] md, input logic [3:0] mdat);
    freeze         = fr;
    bus4.alu_valid = av;   bus3.alu_valid = av;
    bus4.alu_dest  = ad;   bus3.alu_dest  = ad;
    bus4.alu_data  = adat; bus3.alu_data  = adat;
    bus4.mem_valid = mv;   bus3.mem_valid = mv;
    bus4.mem_dest  = md;   bus3.mem_dest  = md;
    bus4.mem_data  = mdat; bus3.mem_data  = mdat;
  endtask

  // One clock: drive, check readies against the arbitration rules, record any acceptance.
  task automatic step(input bit fr, input bit av, input logic [1:0] ad, input logic [3:0] adat,
                      input bit mv, input logic [1:0] md, input logic [3:0] mdat,
                      output bit ga, output bit gm);
    drive(fr, av, ad, adat, mv, md, mdat);
    #1;
    ga = 1'b0;
    gm = 1'b0;
    if (!fr) begin
      if (av && mv) begin
        if (rr_alu) ga = 1'b1;
        else        gm = 1'b1;
        rr_alu = !rr_alu;
      end else begin
        ga = av;
        gm = mv;
      end
    end
    chk("alu_ready4", 32'(bus4.alu_ready), 32'(ga));
    chk("mem_ready4", 32'(bus4.mem_ready), 32'(gm));
    chk("alu_ready3", 32'(bus3.alu_ready), 32'(ga));
    chk("mem_ready3", 32'(bus3.mem_ready), 32'(gm));
    @(posedge clock);
    #1;
    if (ga)      push_write(ad, adat);
    else if (gm) push_write(md, mdat);
  endtask

  task automatic idle(input int n);
    bit ga, gm;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, ga, gm);
  endtask

  task automatic reset_checks();
    chk("rst_reg_set4", 32'(reg_set4), 32'd0);
    chk("rst_reg_set3", 32'(reg_set3), 32'd0);
    chk("rst_reg_value4", 32'(reg_value4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_count4", 32'(write_count4), 32'd0);
    chk("rst_count3", 32'(write_count3), 32'd0);
    chk("rst_err4", 32'(err_dest4), 32'd0);
    chk("rst_err3", 32'(err_dest3), 32'd0);
  endtask

  task automatic clear_model();
    sbq.delete();
    rr_alu    = 1'b1;
    exp_cnt   = 8'd0;
    last_val4 = 4'd0;
    exp_err3  = 1'b0;
  endtask

  // Asserts reset mid-cycle, well away from either clock edge.
  task automatic do_reset();
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
    #6;
    reset = 1'b0;
    clear_model();
    #1;
    reset_checks();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
  endtask

  // Monitor: pops one expected write whenever the DUT presents a strobe cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (busy4) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: reg_set=%b with no write outstanding (t=%0t)",
                     reg_set4, $time);
          end else begin
            e = sbq.pop_front();
            chk("reg_set4", 32'(reg_set4), 32'(e.set4));
            chk("reg_set3", 32'(reg_set3), 32'(e.set3));
            chk("busy3", 32'(busy3), 32'd1);
            if (e.in3) chk("reg_value3", 32'(reg_value3), 32'(e.val));
          end
        end else begin
          chk("missing_pulse", 32'(sbq.size()), 32'd0);
          if (sbq.size() > 0) void'(sbq.pop_front());
          chk("idle_reg_set4", 32'(reg_set4), 32'd0);
          chk("idle_reg_set3", 32'(reg_set3), 32'd0);
          chk("idle_busy3", 32'(busy3), 32'd0);
        end
        chk("reg_value4", 32'(reg_value4), 32'(last_val4));
        chk("write_count4", 32'(write_count4), 32'(exp_cnt));
        chk("write_count3", 32'(write_count3), 32'(exp_cnt));
        chk("err_dest4", 32'(err_dest4), 32'd0);
        chk("err_dest3", 32'(err_dest3), 32'(exp_err3));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit         ga, gm;
    bit         av, mv, fr;
    logic [1:0] ad, md;
    logic [3:0] adat, mdat;

    reset = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
    clear_model();
    #2;
    reset_checks();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;

    // Reset arriving while a strobe is live drops it immediately.
    step(1'b0, 1'b1, 2'd1, 4'hA, 1'b0, 2'd0, 4'd0, ga, gm);
    do_reset();
    idle(3);

    // Single ALU write.
    step(1'b0, 1'b1, 2'd2, 4'h5, 1'b0, 2'd0, 4'd0, ga, gm);
    idle(2);

    // Contention: grants alternate ALU, MEM, ALU, MEM.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd0, 4'h1, 1'b1, 2'd3, 4'h6, ga, gm);
    idle(2);

    // Freeze holds off a pending load, which issues once released.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 4'h9, ga, gm);
    step(1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 4'h9, ga, gm);
    idle(2);

    // Same register back to back.
    step(1'b0, 1'b1, 2'd0, 4'h3, 1'b0, 2'd0, 4'd0, ga, gm);
    step(1'b0, 1'b1, 2'd0, 4'h7, 1'b0, 2'd0, 4'd0, ga, gm);
    idle(2);

    // 256 accepted writes wrap the counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           1'b0, 2'd0, 4'd0, ga, gm);
    end
    idle(1);
    chk("wrap_count4", 32'(write_count4), 32'd0);
    chk("wrap_count3", 32'(write_count3), 32'd0);

    // Randomized sources that hold their request until accepted.
    av = 1'b0; mv = 1'b0; ad = 2'd0; md = 2'd0; adat = 4'd0; mdat = 4'd0;
    for (int i = 0; i < 800; i++) begin
      fr = ($urandom_range(0, 7) == 0);
      if (!av && $urandom_range(0, 3) != 0) begin
        av = 1'b1; ad = 2'($urandom_range(0, 3)); adat = 4'($urandom_range(0, 15));
      end
      if (!mv && $urandom_range(0, 3) != 0) begin
        mv = 1'b1; md = 2'($urandom_range(0, 3)); mdat = 4'($urandom_range(0, 15));
      end
      step(fr, av, ad, adat, mv, md, mdat, ga, gm);
      if (ga) av = 1'b0;
      if (gm) mv = 1'b0;
    end
    idle(3);

    do_reset();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
